// File: rtl/cache_mem_arbiter_pkg.sv
// rtl/cache_mem_arbiter_pkg.sv - shared types for the cache-to-memory arbiter
package rv32i_types;

    localparam int CACHELINE_W = 256;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_SERVE_I = 2'd1,
        ARB_SERVE_D = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic [31:0]            addr;
        logic                   write;
        logic [CACHELINE_W-1:0] wdata;
    } arb_req_t;

    function automatic logic [31:0] line_align(input logic [31:0] a);
        return a & 32'hFFFF_FFE0;
    endfunction

endpackage

// File: rtl/cache_mem_arbiter_if.sv
// rtl/cache_mem_arbiter_if.sv - cache-side and memory-side signals of the arbiter
interface cache_mem_arbiter_if;
    import rv32i_types::*;

    logic [31:0]            i_addr;
    logic                   i_read;
    logic [CACHELINE_W-1:0] i_rdata;
    logic                   i_resp;

    logic [31:0]            d_addr;
    logic                   d_read;
    logic                   d_write;
    logic [CACHELINE_W-1:0] d_wdata;
    logic [CACHELINE_W-1:0] d_rdata;
    logic                   d_resp;

    logic [31:0]            mem_addr;
    logic                   mem_read;
    logic                   mem_write;
    logic [CACHELINE_W-1:0] mem_wdata;
    logic [CACHELINE_W-1:0] mem_rdata;
    logic                   mem_resp;

    modport slave (
        input  i_addr, i_read, d_addr, d_read, d_write, d_wdata, mem_rdata, mem_resp,
        output i_rdata, i_resp, d_rdata, d_resp, mem_addr, mem_read, mem_write, mem_wdata
    );

    modport master (
        output i_addr, i_read, d_addr, d_read, d_write, d_wdata, mem_rdata, mem_resp,
        input  i_rdata, i_resp, d_rdata, d_resp, mem_addr, mem_read, mem_write, mem_wdata
    );

endinterface

// File: rtl/cache_mem_arbiter_rr_pick2.sv
// rtl/cache_mem_arbiter_rr_pick2.sv - combinational two-way round-robin picker
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt,
    output logic       valid
);

    // On a tie the side that was not granted last wins; last=1 means req[1] won last.
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

    assign valid = |req;

endmodule

// File: rtl/cache_mem_arbiter.sv
// rtl/cache_mem_arbiter.sv - shares one cacheline memory port between icache and dcache
module cache_mem_arbiter
    import rv32i_types::*;
(
    input  logic                clk,
    input  logic                rst,
    cache_mem_arbiter_if.slave  bus
);

    arb_state_t r_state;
    logic       r_last_grant;   // 1 = dcache granted last
    arb_req_t   r_req;

    logic [1:0] w_req;
    logic [1:0] w_gnt;
    logic       w_valid;
    logic       w_busy;

    assign w_req = {bus.d_read | bus.d_write, bus.i_read};

    rr_pick2 u_pick (
        .req   (w_req),
        .last  (r_last_grant),
        .gnt   (w_gnt),
        .valid (w_valid)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ARB_IDLE;
            r_last_grant <= 1'b1;
            r_req        <= '0;
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    if (w_valid) begin
                        if (w_gnt[0]) begin
                            r_state      <= ARB_SERVE_I;
                            r_last_grant <= 1'b0;
                            r_req.addr   <= line_align(bus.i_addr);
                            r_req.write  <= 1'b0;
                            r_req.wdata  <= '0;
                        end else begin
                            // read+write together is illegal upstream; the write wins
                            r_state      <= ARB_SERVE_D;
                            r_last_grant <= 1'b1;
                            r_req.addr   <= line_align(bus.d_addr);
                            r_req.write  <= bus.d_write;
                            r_req.wdata  <= bus.d_write ? bus.d_wdata : '0;
                        end
                    end
                end
                ARB_SERVE_I, ARB_SERVE_D: begin
                    if (bus.mem_resp) r_state <= ARB_IDLE;
                end
                default: r_state <= ARB_IDLE;
            endcase
        end
    end

    assign w_busy        = (r_state != ARB_IDLE);
    assign bus.mem_addr  = r_req.addr;
    assign bus.mem_wdata = r_req.wdata;
    assign bus.mem_read  = w_busy & ~r_req.write;
    assign bus.mem_write = w_busy & r_req.write;

    assign bus.i_resp  = (r_state == ARB_SERVE_I) & bus.mem_resp;
    assign bus.d_resp  = (r_state == ARB_SERVE_D) & bus.mem_resp;
    assign bus.i_rdata = bus.mem_rdata;
    assign bus.d_rdata = bus.mem_rdata;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb/tb_cache_mem_arbiter.sv - directed self-checking bench for cache_mem_arbiter
module tb_cache_mem_arbiter;
    import rv32i_types::*;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    cache_mem_arbiter_if bus ();

    cache_mem_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst) assert (!(bus.d_read && bus.d_write)) else $error("illegal d_read and d_write together");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++; if (bus.mem_read !== 1'b0) begin errors++; $display("FAIL reset_mem_read: got %0b want 0", bus.mem_read); end
        checks++; if (bus.mem_write !== 1'b0) begin errors++; $display("FAIL reset_mem_write: got %0b want 0", bus.mem_write); end
        checks++; if (bus.mem_addr !== 32'h0) begin errors++; $display("FAIL reset_mem_addr: got %h want 0", bus.mem_addr); end
        checks++; if (bus.mem_wdata !== 256'h0) begin errors++; $display("FAIL reset_mem_wdata: got %h want 0", bus.mem_wdata); end
        checks++; if (bus.i_resp !== 1'b0 || bus.d_resp !== 1'b0) begin errors++; $display("FAIL reset_resp: got i=%0b d=%0b want 0 0", bus.i_resp, bus.d_resp); end
        checks++; if (dut.r_state !== ARB_IDLE) begin errors++; $display("FAIL reset_state: got %0d want %0d", dut.r_state, ARB_IDLE); end
        checks++; if (dut.r_last_grant !== 1'b1) begin errors++; $display("FAIL reset_last_grant: got %0b want 1", dut.r_last_grant); end
    endtask

    task automatic test_single_iread();
        logic [255:0] pat;
        pat = {8{32'hDEADBEEF}};
        bus.i_addr = 32'h0000_1047;
        bus.i_read = 1'b1;
        cyc();
        checks++; if (bus.mem_read !== 1'b1) begin errors++; $display("FAIL single_mem_read: got %0b want 1", bus.mem_read); end
        checks++; if (bus.mem_addr !== 32'h0000_1040) begin errors++; $display("FAIL single_mem_addr: got %h want 00001040", bus.mem_addr); end
        cyc();
        cyc();
        bus.mem_rdata = pat;
        bus.mem_resp  = 1'b1;
        #1;
        checks++; if (bus.i_resp !== 1'b1) begin errors++; $display("FAIL single_i_resp: got %0b want 1", bus.i_resp); end
        checks++; if (bus.i_rdata !== pat) begin errors++; $display("FAIL single_i_rdata: got %h want %h", bus.i_rdata, pat); end
        checks++; if (bus.d_resp !== 1'b0) begin errors++; $display("FAIL single_d_resp: got %0b want 0", bus.d_resp); end
        checks++; if (bus.mem_read !== 1'b1) begin errors++; $display("FAIL single_read_held: got %0b want 1", bus.mem_read); end
        cyc();
        bus.mem_resp = 1'b0;
        bus.i_read   = 1'b0;
        #1;
        checks++; if (bus.i_resp !== 1'b0) begin errors++; $display("FAIL single_i_resp_width: got %0b want 0", bus.i_resp); end
        checks++; if (bus.mem_read !== 1'b0) begin errors++; $display("FAIL single_read_drop: got %0b want 0", bus.mem_read); end
        cyc();
    endtask

    task automatic test_tie();
        logic exp_i;
        do_reset();
        bus.i_addr = 32'h0000_0100;
        bus.d_addr = 32'h0000_0200;
        bus.i_read = 1'b1;
        bus.d_read = 1'b1;
        for (int k = 0; k < 4; k++) begin
            exp_i = (k % 2 == 0);
            cyc();
            checks++; if (bus.mem_addr !== (exp_i ? 32'h0000_0100 : 32'h0000_0200) || bus.mem_read !== 1'b1) begin
                errors++; $display("FAIL tie_grant_%0d: got addr=%h rd=%0b want addr=%h rd=1", k, bus.mem_addr, bus.mem_read, exp_i ? 32'h100 : 32'h200);
            end
            bus.mem_resp = 1'b1;
            #1;
            checks++; if (bus.i_resp !== exp_i || bus.d_resp !== !exp_i) begin
                errors++; $display("FAIL tie_resp_%0d: got i=%0b d=%0b want i=%0b d=%0b", k, bus.i_resp, bus.d_resp, exp_i, !exp_i);
            end
            cyc();
            bus.mem_resp = 1'b0;
            #1;
            checks++; if (bus.mem_read !== 1'b0) begin errors++; $display("FAIL tie_gap_%0d: got %0b want 0", k, bus.mem_read); end
        end
        bus.i_read = 1'b0;
        bus.d_read = 1'b0;
        cyc();
    endtask

    task automatic test_busy();
        logic [255:0] wd;
        wd = {32{8'hA5}};
        do_reset();
        bus.d_addr  = 32'h8000_0020;
        bus.d_wdata = wd;
        bus.d_write = 1'b1;
        cyc();
        checks++; if (bus.mem_write !== 1'b1 || bus.mem_addr !== 32'h8000_0020) begin errors++; $display("FAIL busy_grant: got wr=%0b addr=%h want wr=1 addr=80000020", bus.mem_write, bus.mem_addr); end
        bus.i_addr  = 32'h0000_3000;
        bus.i_read  = 1'b1;
        bus.d_addr  = 32'h0000_0000;
        bus.d_wdata = '0;
        cyc();
        checks++; if (bus.mem_addr !== 32'h8000_0020) begin errors++; $display("FAIL busy_addr_hold: got %h want 80000020", bus.mem_addr); end
        checks++; if (bus.mem_wdata !== wd) begin errors++; $display("FAIL busy_wdata_hold: got %h want %h", bus.mem_wdata, wd); end
        checks++; if (bus.mem_read !== 1'b0) begin errors++; $display("FAIL busy_no_read: got %0b want 0", bus.mem_read); end
        cyc();
        bus.mem_resp = 1'b1;
        #1;
        checks++; if (bus.d_resp !== 1'b1 || bus.i_resp !== 1'b0) begin errors++; $display("FAIL busy_resp: got d=%0b i=%0b want d=1 i=0", bus.d_resp, bus.i_resp); end
        cyc();
        bus.mem_resp = 1'b0;
        bus.d_write  = 1'b0;
        #1;
        checks++; if (bus.mem_read !== 1'b0 || bus.mem_write !== 1'b0) begin errors++; $display("FAIL busy_turnaround: got rd=%0b wr=%0b want 0 0", bus.mem_read, bus.mem_write); end
        cyc();
        checks++; if (bus.mem_read !== 1'b1 || bus.mem_addr !== 32'h0000_3000) begin errors++; $display("FAIL busy_i_grant: got rd=%0b addr=%h want rd=1 addr=00003000", bus.mem_read, bus.mem_addr); end
        bus.mem_resp = 1'b1;
        cyc();
        bus.mem_resp = 1'b0;
        bus.i_read   = 1'b0;
        cyc();
    endtask

    task automatic test_back_to_back();
        bus.d_read = 1'b1;
        for (int k = 0; k < 2; k++) begin
            bus.d_addr = 32'h0000_0403 + 32'(k) * 32'h20;
            cyc();
            checks++; if (bus.mem_read !== 1'b1 || bus.mem_addr !== 32'h0000_0400 + 32'(k) * 32'h20) begin
                errors++; $display("FAIL b2b_grant_%0d: got rd=%0b addr=%h want rd=1 addr=%h", k, bus.mem_read, bus.mem_addr, 32'h400 + 32'(k) * 32'h20);
            end
            bus.mem_resp = 1'b1;
            #1;
            checks++; if (bus.d_resp !== 1'b1) begin errors++; $display("FAIL b2b_resp_%0d: got %0b want 1", k, bus.d_resp); end
            cyc();
            bus.mem_resp = 1'b0;
        end
        bus.d_read = 1'b0;
        #1;
        checks++; if (dut.r_last_grant !== 1'b1) begin errors++; $display("FAIL b2b_last_grant: got %0b want 1", dut.r_last_grant); end
        cyc();
        checks++; if (dut.r_last_grant !== 1'b1) begin errors++; $display("FAIL b2b_last_grant_idle: got %0b want 1", dut.r_last_grant); end
    endtask

    task automatic test_reset_mid();
        bus.d_addr = 32'h0000_0500;
        bus.d_read = 1'b1;
        cyc();
        checks++; if (dut.r_state !== ARB_SERVE_D) begin errors++; $display("FAIL rmid_serving: got %0d want %0d", dut.r_state, ARB_SERVE_D); end
        rst        = 1'b1;
        bus.d_read = 1'b0;
        cyc();
        rst          = 1'b0;
        bus.mem_resp = 1'b1;
        #1;
        checks++; if (bus.d_resp !== 1'b0 || bus.i_resp !== 1'b0) begin errors++; $display("FAIL rmid_resp: got d=%0b i=%0b want 0 0", bus.d_resp, bus.i_resp); end
        checks++; if (bus.mem_read !== 1'b0 || bus.mem_write !== 1'b0 || bus.mem_addr !== 32'h0) begin errors++; $display("FAIL rmid_outputs: got rd=%0b wr=%0b addr=%h want 0 0 0", bus.mem_read, bus.mem_write, bus.mem_addr); end
        checks++; if (dut.r_state !== ARB_IDLE) begin errors++; $display("FAIL rmid_state: got %0d want %0d", dut.r_state, ARB_IDLE); end
        cyc();
        bus.mem_resp = 1'b0;
        #1;
        checks++; if (dut.r_state !== ARB_IDLE) begin errors++; $display("FAIL rmid_state_after: got %0d want %0d", dut.r_state, ARB_IDLE); end
    endtask

    task automatic test_stray();
        bus.mem_resp = 1'b1;
        #1;
        checks++; if (bus.i_resp !== 1'b0 || bus.d_resp !== 1'b0) begin errors++; $display("FAIL stray_resp: got i=%0b d=%0b want 0 0", bus.i_resp, bus.d_resp); end
        cyc();
        bus.mem_resp = 1'b0;
        #1;
        checks++; if (dut.r_state !== ARB_IDLE || bus.mem_read !== 1'b0) begin errors++; $display("FAIL stray_state: got st=%0d rd=%0b want %0d 0", dut.r_state, bus.mem_read, ARB_IDLE); end
        checks++; if (dut.r_last_grant !== 1'b1) begin errors++; $display("FAIL stray_last_grant: got %0b want 1", dut.r_last_grant); end
    endtask

    initial begin
        errors        = 0;
        checks        = 0;
        rst           = 1'b1;
        bus.i_addr    = '0;
        bus.i_read    = 1'b0;
        bus.d_addr    = '0;
        bus.d_read    = 1'b0;
        bus.d_write   = 1'b0;
        bus.d_wdata   = '0;
        bus.mem_rdata = '0;
        bus.mem_resp  = 1'b0;

        test_reset();
        test_single_iread();
        test_tie();
        test_busy();
        test_back_to_back();
        test_reset_mid();
        test_stray();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
